btn_lockout_sched: RTL and testbench

//  Schedules N raw push-button inputs onto one shared lockout counter, so one timer replaces one per button.

---
 rtl/btn_sched_pkg.sv | 24 ++
 rtl/btn_lockout_sched_rr_arbiter.sv | 18 +
 rtl/btn_lockout_sched.sv | 94 +++++++++
 tb/tb_btn_lockout_sched.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/btn_sched_pkg.sv
// btn_sched_pkg: shared FSM state type and round-robin pick helper for the button lockout scheduler
package btn_sched_pkg;
   typedef enum logic [1:0] {IDLE, GRANT, LOCK} state_t;
   localparam int unsigned MAX_BTN = 32;
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   // First set request scanning upward from ptr+1, wrapping at n; returns ptr when nothing is set.
   function automatic int unsigned rr_pick(input logic [MAX_BTN-1:0] req, input int unsigned ptr,
                                           input int unsigned n);
      int unsigned idx;
      logic found;
      rr_pick = ptr;
      found = 1'b0;
      for (int unsigned i = 1; i <= MAX_BTN; i++) begin
         idx = ptr + i;
         if (idx >= n) idx -= n;
         if (!found && i <= n && req[idx[$clog2(MAX_BTN)-1:0]]) begin
            rr_pick = idx;
            found = 1'b1;
         end
      end
   endfunction
endpackage

// File: rtl/btn_lockout_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin selector over pending button requests
module rr_arbiter import btn_sched_pkg::*; #(
   parameter int unsigned N = 4,
   localparam int unsigned W = idx_w(N)
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] ptr_i,
   output logic [W-1:0] gnt_idx_o,
   output logic         gnt_vld_o
);
   logic [MAX_BTN-1:0] req_w;
   always_comb begin
      req_w = '0;
      req_w[N-1:0] = req_i;
   end
   assign gnt_idx_o = W'(rr_pick(req_w, 32'(ptr_i), N));
   assign gnt_vld_o = |req_i;
endmodule

// File: rtl/btn_lockout_sched.sv
// btn_lockout_sched: synchronises N buttons, queues rising edges and grants them round-robin
// behind one shared lockout counter.
module btn_lockout_sched import btn_sched_pkg::*; #(
   parameter int unsigned N_BTN       = 4,
   parameter int unsigned DELAY_G     = 50_000_000,
   parameter int unsigned SYNC_STAGES = 2,
   localparam int unsigned IDX_W      = idx_w(N_BTN)
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [N_BTN-1:0] btn_i,
   output logic [N_BTN-1:0] cmd_o,
   output logic [IDX_W-1:0] cmd_idx_o,
   output logic             busy_o,
   output logic [N_BTN-1:0] pending_o,
   output logic             coalesce_o
);
   localparam int unsigned CNT_W = $clog2(DELAY_G);
   logic [N_BTN-1:0] sync_q [SYNC_STAGES];
   logic [N_BTN-1:0] s_d_q, pending_q, pending_d, cmd_q, cmd_d, sel_oh, edge_v;
   logic [IDX_W-1:0] sel_q, sel_d, ptr_q, ptr_d, idx_q, idx_d, gnt_idx;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             gnt_vld, busy_q, coal_q;
   state_t           state_q, state_d;

   rr_arbiter #(.N(N_BTN)) u_arb (
      .req_i    (pending_q),
      .ptr_i    (ptr_q),
      .gnt_idx_o(gnt_idx),
      .gnt_vld_o(gnt_vld)
   );

   always_comb begin
      sel_oh = N_BTN'(1) << sel_q;
      // The granted button's edges are bounce for the whole grant + lockout window.
      edge_v = sync_q[SYNC_STAGES-1] & ~s_d_q & ~((state_q == IDLE) ? '0 : sel_oh);
      pending_d = (pending_q | edge_v) & ~((state_q == GRANT) ? sel_oh : '0);
      cmd_d = (state_q == GRANT) ? sel_oh : '0;
      state_d = state_q;
      sel_d = sel_q;
      ptr_d = ptr_q;
      idx_d = idx_q;
      cnt_d = cnt_q;
      case (state_q)
         IDLE: if (gnt_vld) begin
            state_d = GRANT;
            sel_d = gnt_idx;
         end
         GRANT: begin
            state_d = LOCK;
            ptr_d = sel_q;
            idx_d = sel_q;
            cnt_d = CNT_W'(DELAY_G - 1);
         end
         LOCK: if (cnt_q == '0) state_d = IDLE; else cnt_d = cnt_q - 1'b1;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         s_d_q <= '0;
         pending_q <= '0;
         cmd_q <= '0;
         sel_q <= '0;
         ptr_q <= IDX_W'(N_BTN - 1);
         idx_q <= '0;
         cnt_q <= '0;
         busy_q <= 1'b0;
         coal_q <= 1'b0;
         state_q <= IDLE;
      end else begin
         sync_q[0] <= btn_i;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         s_d_q <= sync_q[SYNC_STAGES-1];
         pending_q <= pending_d;
         cmd_q <= cmd_d;
         sel_q <= sel_d;
         ptr_q <= ptr_d;
         idx_q <= idx_d;
         cnt_q <= cnt_d;
         busy_q <= state_q != IDLE;
         coal_q <= |(edge_v & pending_q);
         state_q <= state_d;
      end
   end

   assign cmd_o = cmd_q;
   assign cmd_idx_o = idx_q;
   assign busy_o = busy_q;
   assign pending_o = pending_q;
   assign coalesce_o = coal_q;
endmodule

// File: tb/tb_btn_lockout_sched.sv
// tb_btn_lockout_sched: directed scenarios for btn_lockout_sched with N_BTN=4, DELAY_G=8, SYNC_STAGES=2
module tb_btn_lockout_sched;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] btn = '0;
   logic [3:0] cmd_o, pending_o;
   logic [1:0] cmd_idx_o;
   logic       busy_o, coalesce_o;
   int         n_checks = 0;
   int         n_fails = 0;

   btn_lockout_sched #(.N_BTN(4), .DELAY_G(8), .SYNC_STAGES(2)) dut (
      .clk_i     (clk),
      .rst_n_i   (rst_n),
      .btn_i     (btn),
      .cmd_o     (cmd_o),
      .cmd_idx_o (cmd_idx_o),
      .busy_o    (busy_o),
      .pending_o (pending_o),
      .coalesce_o(coalesce_o)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench #1 after a clock edge with reset released; that point is k=0.
   task automatic do_reset();
      rst_n = 1'b0;
      btn = '0;
      repeat (3) step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      btn = '0;
      repeat (2) step();
      n_checks++;
      if ({cmd_o, cmd_idx_o, busy_o, pending_o, coalesce_o} !== 12'd0) begin
         n_fails++;
         $display("FAIL reset_outputs got %b exp 0", {cmd_o, cmd_idx_o, busy_o, pending_o, coalesce_o});
      end
      rst_n = 1'b1;
      repeat (5) step();
      n_checks++;
      if ({cmd_o, busy_o, pending_o, coalesce_o} !== 10'd0) begin
         n_fails++;
         $display("FAIL reset_idle got %b exp 0", {cmd_o, busy_o, pending_o, coalesce_o});
      end
   endtask

   task automatic test_single_press();
      do_reset();
      btn = 4'b0100;
      for (int k = 1; k <= 25; k++) begin
         step();
         if (k == 20) btn = '0;
         n_checks++;
         if (cmd_o !== ((k == 5) ? 4'b0100 : 4'b0000)) begin
            n_fails++;
            $display("FAIL t1_cmd k=%0d got %b exp %b", k, cmd_o, (k == 5) ? 4'b0100 : 4'b0000);
         end
         n_checks++;
         if (busy_o !== (k >= 5 && k <= 13)) begin
            n_fails++;
            $display("FAIL t1_busy k=%0d got %b exp %b", k, busy_o, (k >= 5 && k <= 13));
         end
      end
      n_checks++;
      if (cmd_idx_o !== 2'd2) begin
         n_fails++;
         $display("FAIL t1_idx got %0d exp 2", cmd_idx_o);
      end
   endtask

   task automatic test_bounce();
      int pulses = 0;
      do_reset();
      btn = 4'b0010;
      for (int k = 1; k <= 30; k++) begin
         step();
         if (k <= 6) btn[1] = ~btn[1];
         if (cmd_o != '0) begin
            pulses++;
            n_checks++;
            if (cmd_o !== 4'b0010) begin
               n_fails++;
               $display("FAIL t2_cmd k=%0d got %b exp 0010", k, cmd_o);
            end
         end
         if (k >= 5) begin
            n_checks++;
            if (pending_o !== 4'b0000) begin
               n_fails++;
               $display("FAIL t2_pending k=%0d got %b exp 0000", k, pending_o);
            end
         end
      end
      n_checks++;
      if (pulses != 1) begin
         n_fails++;
         $display("FAIL t2_pulses got %0d exp 1", pulses);
      end
   endtask

   task automatic test_simultaneous();
      logic [3:0] exp_cmd, exp_pend;
      do_reset();
      btn = 4'b1011;
      for (int k = 1; k <= 35; k++) begin
         step();
         exp_cmd = (k == 5) ? 4'b0001 : (k == 15) ? 4'b0010 : (k == 25) ? 4'b1000 : 4'b0000;
         exp_pend = (k < 3) ? 4'b0000 : (k < 5) ? 4'b1011 : (k < 15) ? 4'b1010 :
                    (k < 25) ? 4'b1000 : 4'b0000;
         n_checks++;
         if (cmd_o !== exp_cmd) begin
            n_fails++;
            $display("FAIL t3_cmd k=%0d got %b exp %b", k, cmd_o, exp_cmd);
         end
         n_checks++;
         if (pending_o !== exp_pend) begin
            n_fails++;
            $display("FAIL t3_pending k=%0d got %b exp %b", k, pending_o, exp_pend);
         end
      end
   endtask

   task automatic test_fairness();
      logic [3:0] exp_cmd;
      do_reset();
      btn = 4'b1000;
      for (int k = 1; k <= 36; k++) begin
         step();
         if (k == 3) btn = '0;
         if (k == 11) btn = 4'b1001;
         exp_cmd = (k == 5) ? 4'b1000 : (k == 16) ? 4'b0001 : (k == 26) ? 4'b1000 : 4'b0000;
         n_checks++;
         if (cmd_o !== exp_cmd) begin
            n_fails++;
            $display("FAIL t4_cmd k=%0d got %b exp %b", k, cmd_o, exp_cmd);
         end
         if (k == 14) begin
            n_checks++;
            if (pending_o !== 4'b1001) begin
               n_fails++;
               $display("FAIL t4_pending got %b exp 1001", pending_o);
            end
         end
      end
      n_checks++;
      if (cmd_idx_o !== 2'd3) begin
         n_fails++;
         $display("FAIL t4_idx got %0d exp 3", cmd_idx_o);
      end
   endtask

   task automatic test_coalesce();
      logic [3:0] exp_cmd;
      do_reset();
      btn = 4'b0001;
      for (int k = 1; k <= 30; k++) begin
         step();
         if (k == 5 || k == 7) btn = 4'b0101;
         if (k == 6 || k == 8) btn = 4'b0001;
         exp_cmd = (k == 5) ? 4'b0001 : (k == 15) ? 4'b0100 : 4'b0000;
         n_checks++;
         if (cmd_o !== exp_cmd) begin
            n_fails++;
            $display("FAIL t5_cmd k=%0d got %b exp %b", k, cmd_o, exp_cmd);
         end
         n_checks++;
         if (coalesce_o !== (k == 10)) begin
            n_fails++;
            $display("FAIL t5_coalesce k=%0d got %b exp %b", k, coalesce_o, (k == 10));
         end
      end
   endtask

   task automatic test_reset_mid_lock();
      do_reset();
      btn = 4'b0001;
      for (int k = 1; k <= 8; k++) begin
         step();
         if (k == 2) btn = 4'b0111;
      end
      n_checks++;
      if (pending_o !== 4'b0110 || busy_o !== 1'b1) begin
         n_fails++;
         $display("FAIL t6_pre got pending %b busy %b exp 0110 1", pending_o, busy_o);
      end
      rst_n = 1'b0;
      btn = '0;
      #1;
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if ({cmd_o, cmd_idx_o, busy_o, pending_o, coalesce_o} !== 12'd0) begin
            n_fails++;
            $display("FAIL t6_in_reset k=%0d got %b exp 0", k,
                     {cmd_o, cmd_idx_o, busy_o, pending_o, coalesce_o});
         end
         step();
      end
      rst_n = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         step();
         n_checks++;
         if ({cmd_o, busy_o, pending_o} !== 9'd0) begin
            n_fails++;
            $display("FAIL t6_after k=%0d got %b exp 0", k, {cmd_o, busy_o, pending_o});
         end
      end
      btn = 4'b1000;
      for (int k = 1; k <= 8; k++) begin
         step();
         n_checks++;
         if (cmd_o !== ((k == 5) ? 4'b1000 : 4'b0000)) begin
            n_fails++;
            $display("FAIL t6_new_press k=%0d got %b exp %b", k, cmd_o, (k == 5) ? 4'b1000 : 4'b0000);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_bounce();
      test_simultaneous();
      test_fairness();
      test_coalesce();
      test_reset_mid_lock();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
